// File: rtl/ustk_pkg.sv
// Shared constants and types for the microstack RAM.
// Optional parity storage is enabled by defining USTK_PARITY_EN.
package ustk_pkg;

    localparam int USTK_DEPTH = 16;
    localparam int USTK_AW    = 4;
    localparam int USTK_DW    = 14;

    // Occupancy needs one extra code so that "full" (16) is distinct from 0.
    typedef logic [$clog2(USTK_DEPTH + 1)-1:0] depth_t;

    localparam depth_t DEPTH_FULL  = depth_t'(USTK_DEPTH);
    localparam depth_t DEPTH_EMPTY = depth_t'(0);

    // Odd parity bit: the stored word plus this bit always has an odd number of ones.
    function automatic logic odd_parity(input logic [USTK_DW-1:0] data);
        return ~(^data);
    endfunction

endpackage

// File: rtl/ustk_depth_ctr.sv
// Occupancy counter and sticky overflow/underflow flags for the microstack.
// Push has priority over pop; the counter saturates at full and at empty.
module ustk_depth_ctr
    import ustk_pkg::*;
(
    input  logic   mclk_l,
    input  logic   init_l,
    input  logic   push,
    input  logic   pop,
    input  logic   clr,
    output depth_t depth,
    output logic   ovf,
    output logic   unf
);

    logic ovf_set;
    logic unf_set;

    // A pop that coincides with a push is ignored, so it can never underflow.
    assign ovf_set = push && (depth == DEPTH_FULL);
    assign unf_set = !push && pop && (depth == DEPTH_EMPTY);

    // Counter and sticky flags; a set event on the clearing edge wins.
    always_ff @(posedge mclk_l or negedge init_l) begin
        if (!init_l) begin
            depth <= DEPTH_EMPTY;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            if (push) begin
                if (depth != DEPTH_FULL) begin
                    depth <= depth + depth_t'(1);
                end
            end else if (pop) begin
                if (depth != DEPTH_EMPTY) begin
                    depth <= depth - depth_t'(1);
                end
            end
            ovf <= ovf_set | (ovf & ~clr);
            unf <= unf_set | (unf & ~clr);
        end
    end

endmodule

// File: rtl/ustk_ram.sv
// Microsequencer return-address stack: 16 x 14-bit register file with
// combinational read, occupancy tracking and sticky error flags.
// Optional per-entry odd parity is enabled by defining USTK_PARITY_EN;
// without it the parity state does not exist and ustk_perr_h reads 0.
module ustk_ram
    import ustk_pkg::*;
(
    input  logic               mclk_l,
    input  logic               init_l,
    input  logic [USTK_AW-1:0] ustk_addr_h,
    input  logic               push_h,
    input  logic               pop_h,
    input  logic [USTK_DW-1:0] ret_addr_h,
    input  logic               ustk_out_en_l,
    input  logic               clr_err_h,
    input  logic               par_inject_h,
    output logic [USTK_DW-1:0] ustk_h,
    output depth_t             depth_h,
    output logic               ustk_ovf_h,
    output logic               ustk_unf_h,
    output logic               ustk_perr_h
);

    logic [USTK_DW-1:0] mem [USTK_DEPTH];
    logic [USTK_DW-1:0] rd_data;

    // Entry storage; the write address wraps naturally, so a push at full
    // overwrites whatever the pointer selects.
    always_ff @(posedge mclk_l or negedge init_l) begin
        if (!init_l) begin
            for (int i = 0; i < USTK_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push_h) begin
            mem[ustk_addr_h] <= ret_addr_h;
        end
    end

    // Read returns pre-write contents during a same-cycle push (write lands at the edge).
    assign rd_data = mem[ustk_addr_h];
    assign ustk_h  = (!init_l || ustk_out_en_l) ? '0 : rd_data;

    ustk_depth_ctr u_depth_ctr (
        .mclk_l (mclk_l),
        .init_l (init_l),
        .push   (push_h),
        .pop    (pop_h),
        .clr    (clr_err_h),
        .depth  (depth_h),
        .ovf    (ustk_ovf_h),
        .unf    (ustk_unf_h)
    );

`ifdef USTK_PARITY_EN
    logic [USTK_DEPTH-1:0] par_bits;
    logic                  par_mismatch;
    logic                  perr_reg;

    // Parity bits reset to 1 so that a cleared (all-zero) entry already has
    // valid odd parity and reading it never raises a false error.
    always_ff @(posedge mclk_l or negedge init_l) begin
        if (!init_l) begin
            par_bits <= '1;
        end else if (push_h) begin
            par_bits[ustk_addr_h] <= odd_parity(ret_addr_h) ^ par_inject_h;
        end
    end

    // Valid odd parity means data plus parity bit has an odd popcount.
    assign par_mismatch = !ustk_out_en_l && !(^{par_bits[ustk_addr_h], rd_data});

    // Sticky parity error; a detection on the clearing edge wins.
    always_ff @(posedge mclk_l or negedge init_l) begin
        if (!init_l) begin
            perr_reg <= 1'b0;
        end else begin
            perr_reg <= par_mismatch | (perr_reg & ~clr_err_h);
        end
    end

    assign ustk_perr_h = perr_reg;
`else
    // Error injection only has meaning when parity is stored.
    logic unused_par_inject;
    assign unused_par_inject = par_inject_h;
    assign ustk_perr_h       = 1'b0;
`endif

endmodule

// File: tb/tb_ustk_ram.sv
// Directed self-checking bench for ustk_ram with hand-computed expectations.
// Parity expectations follow USTK_PARITY_EN when it is defined for the build.
module tb_ustk_ram;
    import ustk_pkg::*;

    logic               mclk_l;
    logic               init_l;
    logic [USTK_AW-1:0] ustk_addr_h;
    logic               push_h;
    logic               pop_h;
    logic [USTK_DW-1:0] ret_addr_h;
    logic               ustk_out_en_l;
    logic               clr_err_h;
    logic               par_inject_h;
    logic [USTK_DW-1:0] ustk_h;
    depth_t             depth_h;
    logic               ustk_ovf_h;
    logic               ustk_unf_h;
    logic               ustk_perr_h;

    int n_checks;
    int n_fails;

`ifdef USTK_PARITY_EN
    localparam logic PERR_INJ = 1'b1;
`else
    localparam logic PERR_INJ = 1'b0;
`endif

    ustk_ram dut (
        .mclk_l        (mclk_l),
        .init_l        (init_l),
        .ustk_addr_h   (ustk_addr_h),
        .push_h        (push_h),
        .pop_h         (pop_h),
        .ret_addr_h    (ret_addr_h),
        .ustk_out_en_l (ustk_out_en_l),
        .clr_err_h     (clr_err_h),
        .par_inject_h  (par_inject_h),
        .ustk_h        (ustk_h),
        .depth_h       (depth_h),
        .ustk_ovf_h    (ustk_ovf_h),
        .ustk_unf_h    (ustk_unf_h),
        .ustk_perr_h   (ustk_perr_h)
    );

    initial mclk_l = 1'b0;
    always #5 mclk_l = ~mclk_l;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_val);
        n_checks++;
        if (obs !== exp_val) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_val);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    // Advance one edge and land 1 time unit after it.
    task automatic step();
        @(posedge mclk_l);
        #1;
    endtask

    task automatic idle_inputs();
        push_h        = 1'b0;
        pop_h         = 1'b0;
        clr_err_h     = 1'b0;
        par_inject_h  = 1'b0;
        ustk_out_en_l = 1'b1;
    endtask

    // Short reset pulse placed away from the clock edge.
    task automatic pulse_reset();
        idle_inputs();
        init_l = 1'b0;
        #2;
        init_l = 1'b1;
    endtask

    task automatic push_at(input logic [USTK_AW-1:0] a, input logic [USTK_DW-1:0] v);
        ustk_addr_h = a;
        ret_addr_h  = v;
        push_h      = 1'b1;
        step();
        push_h      = 1'b0;
    endtask

    task automatic read_at(input logic [USTK_AW-1:0] a);
        ustk_addr_h   = a;
        ustk_out_en_l = 1'b0;
        #1;
    endtask

    initial begin
        n_checks    = 0;
        n_fails     = 0;
        ustk_addr_h = '0;
        ret_addr_h  = '0;
        idle_inputs();
        init_l = 1'b0;
        #12;

        // Reset state, read forced to 0 while in reset even with enable low
        ustk_out_en_l = 1'b0;
        #1;
        check("rst_ustk_h", 32'(ustk_h), 32'h0);
        check("rst_depth", 32'(depth_h), 32'd0);
        check("rst_flags", {29'd0, ustk_ovf_h, ustk_unf_h, ustk_perr_h}, 32'h0);
        ustk_out_en_l = 1'b1;
        #2;
        init_l = 1'b1;
        step();

        // Push 0x1A5 at addr 3; same-cycle read sees old data
        ustk_addr_h   = 4'd3;
        ret_addr_h    = 14'h1A5;
        push_h        = 1'b1;
        ustk_out_en_l = 1'b0;
        #1;
        check("push_same_cycle_old", 32'(ustk_h), 32'h0);
        step();
        push_h = 1'b0;
        read_at(4'd3);
        check("read_addr3", 32'(ustk_h), 32'h1A5);
        check("depth_after_push", 32'(depth_h), 32'd1);
        ustk_out_en_l = 1'b1;
        #1;
        check("read_disabled", 32'(ustk_h), 32'h0);

        // 17 pushes: wrap to entry 0, depth saturates, overflow sticks
        pulse_reset();
        step();
        for (int i = 0; i < 16; i++) begin
            push_at(USTK_AW'(i), 14'h2000 | 14'(i));
        end
        check("depth_16", 32'(depth_h), 32'd16);
        check("ovf_not_yet", 32'(ustk_ovf_h), 32'd0);
        push_at(4'd0, 14'h3FFF);
        check("depth_hold_16", 32'(depth_h), 32'd16);
        check("ovf_set", 32'(ustk_ovf_h), 32'd1);
        read_at(4'd0);
        check("entry0_17th", 32'(ustk_h), 32'h3FFF);
        read_at(4'd15);
        check("entry15", 32'(ustk_h), 32'h200F);
        ustk_out_en_l = 1'b1;
        step();
        check("ovf_sticky", 32'(ustk_ovf_h), 32'd1);
        clr_err_h = 1'b1;
        step();
        clr_err_h = 1'b0;
        check("ovf_cleared", 32'(ustk_ovf_h), 32'd0);

        // Underflow from empty, then clear; set wins over clear
        pulse_reset();
        step();
        pop_h = 1'b1;
        step();
        pop_h = 1'b0;
        check("unf_depth0", 32'(depth_h), 32'd0);
        check("unf_set", 32'(ustk_unf_h), 32'd1);
        step();
        check("unf_sticky", 32'(ustk_unf_h), 32'd1);
        clr_err_h = 1'b1;
        step();
        check("unf_cleared", 32'(ustk_unf_h), 32'd0);
        pop_h = 1'b1;
        step();
        pop_h     = 1'b0;
        clr_err_h = 1'b0;
        check("unf_set_wins", 32'(ustk_unf_h), 32'd1);

        // Push and pop together at depth 2 -> push wins
        pulse_reset();
        step();
        push_at(4'd0, 14'h0011);
        push_at(4'd1, 14'h0022);
        check("depth_2", 32'(depth_h), 32'd2);
        pop_h = 1'b1;
        push_at(4'd2, 14'h0033);
        pop_h = 1'b0;
        check("push_pop_depth3", 32'(depth_h), 32'd3);
        check("push_pop_flags", {29'd0, ustk_ovf_h, ustk_unf_h, ustk_perr_h}, 32'h0);
        ustk_addr_h   = 4'd2;
        ustk_out_en_l = 1'b1;
        #1;
        check("disabled_read_zero", 32'(ustk_h), 32'h0);
        pop_h = 1'b1;
        step();
        pop_h = 1'b0;
        check("pop_depth2", 32'(depth_h), 32'd2);

        // Parity injection at addr 5
        pulse_reset();
        step();
        par_inject_h = 1'b1;
        push_at(4'd5, 14'h0001);
        par_inject_h = 1'b0;
        read_at(4'd3);
        step();
        check("perr_clean_read", 32'(ustk_perr_h), 32'd0);
        read_at(4'd5);
        check("perr_entry5_data", 32'(ustk_h), 32'h0001);
        step();
        ustk_out_en_l = 1'b1;
        check("perr_inject", 32'(ustk_perr_h), 32'(PERR_INJ));
        clr_err_h = 1'b1;
        step();
        clr_err_h = 1'b0;
        check("perr_cleared", 32'(ustk_perr_h), 32'd0);

        // Reset asserted mid-push at depth 7 with a sticky flag set
        pulse_reset();
        step();
        pop_h = 1'b1;
        step();
        pop_h = 1'b0;
        for (int i = 0; i < 7; i++) begin
            push_at(USTK_AW'(i), 14'h1000 | 14'(i));
        end
        check("depth_7", 32'(depth_h), 32'd7);
        check("unf_before_rst", 32'(ustk_unf_h), 32'd1);
        ustk_addr_h   = 4'd2;
        ret_addr_h    = 14'h0ABC;
        push_h        = 1'b1;
        ustk_out_en_l = 1'b0;
        #3;
        init_l = 1'b0;
        #1;
        check("midrst_depth", 32'(depth_h), 32'd0);
        check("midrst_flags", {29'd0, ustk_ovf_h, ustk_unf_h, ustk_perr_h}, 32'h0);
        check("midrst_ustk_h", 32'(ustk_h), 32'h0);
        push_h = 1'b0;
        #2;
        init_l = 1'b1;
        #1;
        check("post_rst_read2", 32'(ustk_h), 32'h0);
        read_at(4'd0);
        check("post_rst_read0", 32'(ustk_h), 32'h0);
        step();
        check("post_rst_depth", 32'(depth_h), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
